// File: rtl/jedro_1_cpu.sv
// jedro_1_cpu: multi-cycle, non-pipelined RV32I core on synchronous imem/dmem ports.
// Latency: 4 cycles per ALU/branch/jump, 5 per store, 6 per load; memories always answer next cycle.

module jedro_1_cpu_regfile (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);
    logic [31:0] regfile [0:31];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) regfile[i] <= '0;
        end else if (we_i && (waddr_i != 5'd0)) begin
            regfile[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : regfile[raddr1_i];
    assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : regfile[raddr2_i];
endmodule

module jedro_1_cpu #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    output logic                  imem_en_o,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic                  dmem_en_o,
    output logic [3:0]            dmem_we_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_MWAIT, S_WB} state_e;

    state_e      state_q;
    logic [31:0] pc_q, npc_q, ir_q, rs1_q, rs2_q, res_q;
    logic        rd_wen_q;
    logic [1:0]  addr_lo_q;
    logic        imem_en_q, dmem_en_q;
    logic [31:0] imem_addr_q, dmem_addr_q, dmem_wdata_q;
    logic [3:0]  dmem_we_q;

    logic [31:0] rf_rdata1, rf_rdata2;

    jedro_1_cpu_regfile regfile_inst (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .raddr1_i (imem_rdata_i[19:15]),
        .raddr2_i (imem_rdata_i[24:20]),
        .rdata1_o (rf_rdata1),
        .rdata2_o (rf_rdata2),
        .we_i     ((state_q == S_WB) && rd_wen_q),
        .waddr_i  (ir_q[11:7]),
        .wdata_i  (res_q)
    );

    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, pc_plus4;

    assign opcode   = ir_q[6:0];
    assign f3       = ir_q[14:12];
    assign f7       = ir_q[31:25];
    assign imm_i    = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s    = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b    = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u    = {ir_q[31:12], 12'd0};
    assign imm_j    = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign pc_plus4 = pc_q + 32'd4;

    function automatic logic [31:0] alu(input logic [2:0] op, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  alu = alt ? (a - b) : (a + b);
            3'b001:  alu = a << b[4:0];
            3'b010:  alu = {31'd0, $signed(a) < $signed(b)};
            3'b011:  alu = {31'd0, a < b};
            3'b100:  alu = a ^ b;
            3'b101:  alu = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  alu = a | b;
            default: alu = a & b;
        endcase
    endfunction

    logic        ex_legal, ex_wen, ex_load, ex_store, br_taken;
    logic [31:0] ex_res, ex_npc, ex_addr, ex_wdata, alu_b, alu_res;
    logic [3:0]  ex_we;
    logic        alu_alt;

    // SUB/SRA select only for register ops and immediate right shifts; ADDI never subtracts.
    assign alu_b   = (opcode == OP_REG) ? rs2_q : imm_i;
    assign alu_alt = (opcode == OP_REG) ? f7[5] : ((f3 == 3'b101) && f7[5]);
    assign alu_res = alu(f3, alu_alt, rs1_q, alu_b);

    always_comb begin
        case (f3)
            3'b000:  br_taken = (rs1_q == rs2_q);
            3'b001:  br_taken = (rs1_q != rs2_q);
            3'b100:  br_taken = ($signed(rs1_q) < $signed(rs2_q));
            3'b101:  br_taken = ($signed(rs1_q) >= $signed(rs2_q));
            3'b110:  br_taken = (rs1_q < rs2_q);
            3'b111:  br_taken = (rs1_q >= rs2_q);
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        ex_legal = 1'b0;
        ex_wen   = 1'b0;
        ex_load  = 1'b0;
        ex_store = 1'b0;
        ex_res   = 32'd0;
        ex_npc   = pc_plus4;
        ex_addr  = rs1_q + imm_i;
        ex_we    = 4'd0;
        ex_wdata = 32'd0;
        case (opcode)
            OP_LUI:   begin ex_legal = 1'b1; ex_wen = 1'b1; ex_res = imm_u; end
            OP_AUIPC: begin ex_legal = 1'b1; ex_wen = 1'b1; ex_res = pc_q + imm_u; end
            OP_JAL: begin
                ex_legal = 1'b1; ex_wen = 1'b1; ex_res = pc_plus4; ex_npc = pc_q + imm_j;
            end
            OP_JALR: begin
                ex_legal = (f3 == 3'b000); ex_wen = 1'b1; ex_res = pc_plus4;
                ex_npc   = rs1_q + imm_i;
            end
            OP_BRANCH: begin
                ex_legal = (f3[2:1] != 2'b01);
                if (br_taken) ex_npc = pc_q + imm_b;
            end
            OP_LOAD: begin
                ex_legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
                ex_wen   = 1'b1;
                ex_load  = 1'b1;
            end
            OP_STORE: begin
                ex_legal = (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
                ex_store = 1'b1;
                ex_addr  = rs1_q + imm_s;
                case (f3[1:0])
                    2'b00:   begin ex_we = 4'b0001 << ex_addr[1:0]; ex_wdata = {4{rs2_q[7:0]}}; end
                    2'b01:   begin ex_we = 4'b0011 << {ex_addr[1], 1'b0}; ex_wdata = {2{rs2_q[15:0]}}; end
                    default: begin ex_we = 4'hF; ex_wdata = rs2_q; end
                endcase
            end
            OP_IMM: begin
                if (f3 == 3'b001)      ex_legal = (f7 == 7'h00);
                else if (f3 == 3'b101) ex_legal = (f7 == 7'h00) || (f7 == 7'h20);
                else                   ex_legal = 1'b1;
                ex_wen = 1'b1;
                ex_res = alu_res;
            end
            OP_REG: begin
                ex_legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
                ex_wen   = 1'b1;
                ex_res   = alu_res;
            end
            default: ex_legal = 1'b0;
        endcase
        // Anything unrecognised (FENCE, SYSTEM, bad encodings) retires as a plain PC+4.
        if (!ex_legal) begin
            ex_wen   = 1'b0;
            ex_load  = 1'b0;
            ex_store = 1'b0;
            ex_npc   = pc_plus4;
        end
    end

    logic [31:0] ld_shift, ld_val;

    assign ld_shift = dmem_rdata_i >> {addr_lo_q, 3'b000};

    always_comb begin
        case (f3)
            3'b000:  ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_val = {24'd0, ld_shift[7:0]};
            3'b101:  ld_val = {16'd0, ld_shift[15:0]};
            default: ld_val = dmem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_FETCH;
            pc_q         <= BOOT_ADDR;
            npc_q        <= BOOT_ADDR;
            ir_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            res_q        <= '0;
            rd_wen_q     <= 1'b0;
            addr_lo_q    <= 2'd0;
            imem_en_q    <= 1'b0;
            imem_addr_q  <= '0;
            dmem_en_q    <= 1'b0;
            dmem_we_q    <= 4'd0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
        end else begin
            case (state_q)
                // Out of reset the enable is low, so the first FETCH spends a cycle raising it.
                S_FETCH: begin
                    if (imem_en_q) begin
                        imem_en_q <= 1'b0;
                        state_q   <= S_DECODE;
                    end else begin
                        imem_en_q   <= 1'b1;
                        imem_addr_q <= pc_q;
                    end
                end
                S_DECODE: begin
                    ir_q    <= imem_rdata_i;
                    rs1_q   <= rf_rdata1;
                    rs2_q   <= rf_rdata2;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    res_q     <= ex_res;
                    rd_wen_q  <= ex_wen;
                    npc_q     <= {ex_npc[31:2], 2'b00};
                    addr_lo_q <= ex_addr[1:0];
                    if (ex_load || ex_store) begin
                        dmem_en_q   <= 1'b1;
                        dmem_we_q   <= ex_store ? ex_we : 4'd0;
                        dmem_addr_q <= {ex_addr[31:2], 2'b00};
                        if (ex_store) dmem_wdata_q <= ex_wdata;
                        state_q     <= S_MEM;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    dmem_en_q <= 1'b0;
                    dmem_we_q <= 4'd0;
                    state_q   <= ex_load ? S_MWAIT : S_WB;
                end
                S_MWAIT: begin
                    res_q   <= ld_val;
                    state_q <= S_WB;
                end
                S_WB: begin
                    pc_q        <= npc_q;
                    rd_wen_q    <= 1'b0;
                    imem_en_q   <= 1'b1;
                    imem_addr_q <= npc_q;
                    state_q     <= S_FETCH;
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign imem_addr_o  = imem_addr_q;
    assign imem_en_o    = imem_en_q;
    assign dmem_addr_o  = dmem_addr_q;
    assign dmem_en_o    = dmem_en_q;
    assign dmem_we_o    = dmem_we_q;
    assign dmem_wdata_o = dmem_wdata_q;
endmodule

// File: tb/tb_jedro_1_cpu.sv
// Directed-program bench for jedro_1_cpu with behavioural synchronous instruction/data memories.
module tb_jedro_1_cpu;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] imem_addr_o, imem_rdata_i, dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic        imem_en_o, dmem_en_o;
    logic [3:0]  dmem_we_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    jedro_1_cpu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BOOT_ADDR(32'h0)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .imem_addr_o  (imem_addr_o),
        .imem_en_o    (imem_en_o),
        .imem_rdata_i (imem_rdata_i),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_en_o    (dmem_en_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_rdata_i (dmem_rdata_i)
    );

    logic [31:0] imem [0:63];
    logic [31:0] dmem [0:63];
    logic        dmem_clr = 1'b0;
    int          cyc = 0;
    int          fetch_cyc [0:63];
    logic [3:0]  we_log [0:31];
    int          we_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (imem_en_o) imem_rdata_i <= imem[imem_addr_o[7:2]];
        if (dmem_clr) begin
            for (int k = 0; k < 64; k++) dmem[k] <= 32'd0;
        end else if (dmem_en_o) begin
            if (dmem_we_o == 4'd0) dmem_rdata_i <= dmem[dmem_addr_o[7:2]];
            for (int b = 0; b < 4; b++)
                if (dmem_we_o[b]) dmem[dmem_addr_o[7:2]][8*b +: 8] <= dmem_wdata_o[8*b +: 8];
        end
    end

    always @(negedge clk) begin
        if (imem_en_o && !rst_i) fetch_cyc[imem_addr_o[7:2]] <= cyc;
        if (dmem_en_o && (dmem_we_o != 4'd0) && (we_cnt < 32)) begin
            we_log[we_cnt] <= dmem_we_o;
            we_cnt <= we_cnt + 1;
        end
    end

    function automatic logic [31:0] f_i(input int imm, input int rs1, input int f3, input int rd, input int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] f_s(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] f_b(input int f3, input int rs1, input int rs2, input int imm);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] f_j(input int rd, input int imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
    endfunction
    function automatic logic [31:0] f_u(input int imm20, input int rd, input int op);
        return {imm20[19:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] f_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] f_addi(input int rd, input int rs1, input int imm);
        return f_i(imm, rs1, 0, rd, 7'h13);
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        dmem_clr = 1'b1;
        repeat (3) @(negedge clk);
        dmem_clr = 1'b0;
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        bit hit;
        clear_imem();
        @(negedge clk);
        rst_i = 1'b1;
        dmem_clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (imem_en_o !== 1'b0 || imem_addr_o !== 32'd0 || dmem_en_o !== 1'b0 || dmem_we_o !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: imem_en=%b imem_addr=%h dmem_en=%b we=%h, want all 0",
                         i, imem_en_o, imem_addr_o, dmem_en_o, dmem_we_o);
            end
        end
        dmem_clr = 1'b0;
        rst_i = 1'b0;
        for (int r = 1; r < 32; r++) begin
            n_checks++;
            if (dut.regfile_inst.regfile[r] !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_regfile x%0d: got %h, want 00000000", r, dut.regfile_inst.regfile[r]);
            end
        end
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            if (imem_en_o) hit = 1;
        end
        n_checks++;
        if (!hit || imem_addr_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_first_fetch: seen=%0d addr=%h, want fetch at 00000000", hit, imem_addr_o);
        end
    endtask

    task automatic test_bne_loop();
        clear_imem();
        imem[0] = f_addi(1, 0, 3);
        imem[1] = f_addi(2, 0, 0);
        imem[2] = f_addi(2, 2, 1);
        imem[3] = f_addi(1, 1, -1);
        imem[4] = f_b(3'b001, 1, 0, -8);
        imem[5] = f_j(0, 0);
        do_reset();
        repeat (64) @(negedge clk);
        n_checks++;
        if (dut.regfile_inst.regfile[1] !== 32'd0) begin
            n_fail++;
            $display("FAIL bne_loop x1: got %h, want 00000000", dut.regfile_inst.regfile[1]);
        end
        n_checks++;
        if (dut.regfile_inst.regfile[2] !== 32'd3) begin
            n_fail++;
            $display("FAIL bne_loop x2: got %h, want 00000003", dut.regfile_inst.regfile[2]);
        end
    endtask

    task automatic test_branches();
        int          ridx [6] = '{3, 4, 5, 6, 7, 8};
        logic [31:0] rexp [6] = '{32'd0, 32'd0, 32'd9, 32'd0, 32'd0, 32'd0};
        clear_imem();
        imem[0]  = f_addi(1, 0, -1);
        imem[1]  = f_addi(2, 0, 1);
        imem[2]  = f_b(3'b000, 1, 1, 8);
        imem[3]  = f_addi(3, 0, 7);
        imem[4]  = f_b(3'b100, 1, 2, 8);
        imem[5]  = f_addi(4, 0, 7);
        imem[6]  = f_b(3'b110, 1, 2, 8);
        imem[7]  = f_addi(5, 0, 9);
        imem[8]  = f_b(3'b101, 2, 1, 8);
        imem[9]  = f_addi(6, 0, 7);
        imem[10] = f_b(3'b111, 1, 2, 8);
        imem[11] = f_addi(7, 0, 7);
        imem[12] = f_b(3'b001, 1, 2, 8);
        imem[13] = f_addi(8, 0, 7);
        imem[14] = f_j(0, 0);
        do_reset();
        repeat (100) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (dut.regfile_inst.regfile[ridx[k]] !== rexp[k]) begin
                n_fail++;
                $display("FAIL branches x%0d: got %h, want %h", ridx[k], dut.regfile_inst.regfile[ridx[k]], rexp[k]);
            end
        end
    endtask

    task automatic test_memory();
        int          base;
        int          ridx [6] = '{1, 5, 6, 7, 8, 9};
        logic [31:0] rexp [6] = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h0000BEEF, 32'h000000BE,
                                  32'hFFFFDEAD, 32'hDEAD10EF};
        clear_imem();
        imem[0]  = f_u(32'hDEADC, 1, 7'h37);
        imem[1]  = f_addi(1, 1, 32'hEEF);
        imem[2]  = f_addi(2, 0, 32'h10);
        imem[3]  = f_s(0, 1, 2, 3'b010);
        imem[4]  = f_i(3, 2, 3'b000, 5, 7'h03);
        imem[5]  = f_i(0, 2, 3'b101, 6, 7'h03);
        imem[6]  = f_i(1, 2, 3'b100, 7, 7'h03);
        imem[7]  = f_i(2, 2, 3'b001, 8, 7'h03);
        imem[8]  = f_s(1, 2, 2, 3'b000);
        imem[9]  = f_i(0, 2, 3'b010, 9, 7'h03);
        imem[10] = f_j(0, 0);
        base = we_cnt;
        do_reset();
        repeat (120) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (dut.regfile_inst.regfile[ridx[k]] !== rexp[k]) begin
                n_fail++;
                $display("FAIL memory x%0d: got %h, want %h", ridx[k], dut.regfile_inst.regfile[ridx[k]], rexp[k]);
            end
        end
        n_checks++;
        if (we_cnt - base !== 2 || we_log[base] !== 4'hF || we_log[base+1] !== 4'b0010) begin
            n_fail++;
            $display("FAIL memory_we: count=%0d first=%h second=%h, want count=2 first=f second=2",
                     we_cnt - base, we_log[base], we_log[base+1]);
        end
        n_checks++;
        if (dmem[4] !== 32'hDEAD10EF) begin
            n_fail++;
            $display("FAIL memory_word: got %h, want deadbeef with byte1=10 (dead10ef)", dmem[4]);
        end
        n_checks++;
        if (fetch_cyc[4] - fetch_cyc[3] !== 5) begin
            n_fail++;
            $display("FAIL store_latency: got %0d cycles, want 5", fetch_cyc[4] - fetch_cyc[3]);
        end
        n_checks++;
        if (fetch_cyc[5] - fetch_cyc[4] !== 6) begin
            n_fail++;
            $display("FAIL load_latency: got %0d cycles, want 6", fetch_cyc[5] - fetch_cyc[4]);
        end
    endtask

    task automatic test_jumps();
        int          ridx [7] = '{0, 1, 3, 5, 6, 10, 12};
        logic [31:0] rexp [7] = '{32'd0, 32'd4, 32'd16, 32'd28, 32'd1, 32'd0, 32'd0};
        clear_imem();
        imem[0]  = f_j(1, 12);
        imem[1]  = f_addi(10, 0, 7);
        imem[2]  = f_addi(10, 0, 7);
        imem[3]  = f_addi(0, 0, 5);
        imem[4]  = f_u(0, 3, 7'h17);
        imem[5]  = f_addi(4, 0, 45);
        imem[6]  = f_i(0, 4, 3'b000, 5, 7'h67);
        for (int i = 7; i < 11; i++) imem[i] = f_addi(12, 0, 7);
        imem[11] = f_addi(6, 0, 1);
        imem[12] = f_j(0, 0);
        do_reset();
        repeat (80) @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            n_checks++;
            if (dut.regfile_inst.regfile[ridx[k]] !== rexp[k]) begin
                n_fail++;
                $display("FAIL jumps x%0d: got %h, want %h", ridx[k], dut.regfile_inst.regfile[ridx[k]], rexp[k]);
            end
        end
    endtask

    task automatic test_alu();
        int          ridx [9] = '{3, 4, 5, 6, 7, 8, 9, 10, 0};
        logic [31:0] rexp [9] = '{32'hFFFFFFFF, 32'h1FFFFFFF, 32'd11, 32'd1, 32'd0, 32'd7,
                                  32'h80000000, 32'd0, 32'd0};
        clear_imem();
        imem[0]  = f_addi(1, 0, -8);
        imem[1]  = f_addi(2, 0, 3);
        imem[2]  = f_r(7'h20, 2, 1, 3'b101, 3);
        imem[3]  = f_r(7'h00, 2, 1, 3'b101, 4);
        imem[4]  = f_r(7'h20, 1, 2, 3'b000, 5);
        imem[5]  = f_r(7'h00, 2, 1, 3'b010, 6);
        imem[6]  = f_r(7'h00, 2, 1, 3'b011, 7);
        imem[7]  = f_i(-1, 1, 3'b100, 8, 7'h13);
        imem[8]  = f_i(31, 2, 3'b001, 9, 7'h13);
        imem[9]  = 32'h0000_0073;
        imem[10] = f_i(32'h300, 2, 3'b001, 10, 7'h73);
        imem[11] = 32'hFFFF_FFFF;
        imem[12] = f_j(0, 0);
        do_reset();
        repeat (80) @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            n_checks++;
            if (dut.regfile_inst.regfile[ridx[k]] !== rexp[k]) begin
                n_fail++;
                $display("FAIL alu x%0d: got %h, want %h", ridx[k], dut.regfile_inst.regfile[ridx[k]], rexp[k]);
            end
        end
        n_checks++;
        if (fetch_cyc[3] - fetch_cyc[2] !== 4) begin
            n_fail++;
            $display("FAIL alu_latency: got %0d cycles, want 4", fetch_cyc[3] - fetch_cyc[2]);
        end
    endtask

    task automatic test_mid_reset();
        bit hit;
        clear_imem();
        imem[0] = f_addi(2, 0, 32'h10);
        imem[1] = f_addi(1, 0, 5);
        imem[2] = f_s(0, 1, 2, 3'b010);
        imem[3] = f_j(0, 0);
        do_reset();
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (dmem_en_o && dmem_we_o != 4'd0) hit = 1;
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL mid_reset_store_seen: no store issued within 40 cycles, want one");
        end
        rst_i = 1'b1;
        #1;
        n_checks++;
        if (dmem_we_o !== 4'd0 || dmem_en_o !== 1'b0 || imem_en_o !== 1'b0 || imem_addr_o !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: we=%h dmem_en=%b imem_en=%b imem_addr=%h, want all 0",
                     dmem_we_o, dmem_en_o, imem_en_o, imem_addr_o);
        end
        n_checks++;
        if (dut.regfile_inst.regfile[1] !== 32'd0 || dut.regfile_inst.regfile[2] !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset_regs: x1=%h x2=%h, want 0",
                     dut.regfile_inst.regfile[1], dut.regfile_inst.regfile[2]);
        end
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            if (imem_en_o) hit = 1;
        end
        n_checks++;
        if (!hit || imem_addr_o !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset_refetch: seen=%0d addr=%h, want fetch at 00000000", hit, imem_addr_o);
        end
        n_checks++;
        if (dmem[4] !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset_no_write: got %h, want 00000000", dmem[4]);
        end
    endtask

    initial begin
        test_reset();
        test_bne_loop();
        test_branches();
        test_memory();
        test_jumps();
        test_alu();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/jedro_1_cpu.md
Name: jedro_1_cpu

Overview:
- Minimal multi-cycle, non-pipelined RV32I integer core.
- Fetches from a synchronous read-only instruction memory and accesses a synchronous read/write data memory.
- Both memory interfaces (the ram_read_io / ram_rw_io bundles) are flattened into ports.
- Top-level processor block; the system testbench reads its register file hierarchically as regfile_inst.regfile[0:31].

Parameters:
- DATA_WIDTH, 32, datapath and memory word width.
- ADDR_WIDTH, 32, byte address width of both memory ports.
- BOOT_ADDR, 32'h0000_0000, PC value on reset.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- imem_addr_o  out  ADDR_WIDTH  instruction byte address (word aligned).
- imem_en_o  out  1  instruction read enable.
- imem_rdata_i  in  DATA_WIDTH  instruction word, valid one cycle after the enabled read.
- dmem_addr_o  out  ADDR_WIDTH  data byte address (word aligned; lane chosen by we mask).
- dmem_en_o  out  1  data access enable.
- dmem_we_o  out  4  per-byte write enable (0 = read).
- dmem_wdata_o  out  DATA_WIDTH  store data, lane-replicated.
- dmem_rdata_i  in  DATA_WIDTH  load data, valid one cycle after the enabled read.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset:
  - PC = BOOT_ADDR; FSM enters FETCH; all regfile entries = 0.
  - All enables and we = 0; addresses and wdata = 0.
- FSM states:
  - FETCH: imem_en_o=1, imem_addr_o=PC.
  - DECODE: latch imem_rdata_i into IR; read rs1/rs2.
  - EXEC: ALU, branch compare, address calculation.
  - MEM: loads/stores only; dmem_en_o=1.
  - MWAIT: loads only; capture dmem_rdata_i.
  - WB: write rd; update PC; return to FETCH.
- Latency per instruction type:
  - Non-memory: 4 cycles.
  - Store: 5 cycles.
  - Load: 6 cycles.
- Register file:
  - 32x32, named regfile_inst, array regfile.
  - x0 reads 0; writes to x0 are discarded.
  - Read during the WB write cycle returns the old value; the next instruction sees the new one.
- Supported instructions: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP of RV32I.
- Immediates: sign-extended per I/S/B/U/J format.
- Shift amount: low 5 bits of the operand or shamt.
- Arithmetic: wraps modulo 2^32; no overflow trap.
- Branches:
  - Taken: PC = PC + B-imm.
  - Not taken: PC = PC + 4.
  - BNE taken iff rs1 != rs2 (full 32-bit compare).
  - Signed compares for BLT/BGE; unsigned for BLTU/BGEU.
- Jumps:
  - JAL/JALR write PC+4 to rd.
  - JALR target = (rs1 + imm) & ~1.
  - Bit 1 of any target is forced 0; no misalignment exception.
- Stores:
  - dmem_addr_o = addr & ~3.
  - we: SB = 1<<addr[1:0]; SH = 3<<{addr[1],1'b0}; SW = 4'hF.
  - Misaligned SH/SW write the aligned lanes.
- Loads:
  - Select the byte/half by addr[1:0].
  - Sign- or zero-extend per funct3.
- FENCE, ECALL, EBREAK, CSR ops and illegal encodings: execute as NOP (PC+4, no writes).
- PC wrap-around: 32'hFFFF_FFFC + 4 = 0.
- Reset asserted mid-instruction: immediately aborts, clears state, drops enables; no partial write retained.

Test Plan:
- Reset: hold rst_i high 3 cycles -> imem_addr_o=0, imem_en_o=0 during reset; after release first fetch at 0; all x1..x31 = 0.
- BNE loop: program addi x1,x0,3; addi x2,x0,0; loop: addi x2,x2,1; addi x1,x1,-1; bne x1,x0,loop; then idle (jal x0,0); run 64 cycles -> x1=0, x2=3.
- Branch set:
  - beq x1,x1,+8 skips the next addi.
  - blt with x1=-1, x2=1 is taken; bltu with the same values is not taken.
  - -> skipped registers stay 0.
- Memory:
  - sw 0xDEADBEEF to addr 0x10, then lb x5 from 0x13 and lhu x6 from 0x10.
  - -> dmem_we_o=4'hF for the store; x5=0xFFFFFFDE, x6=0x0000BEEF.
- Jumps and x0:
  - jal x1,+12 -> x1=PC+4.
  - addi x0,x0,5 -> x0 remains 0.
  - jalr to odd target -> bit0 cleared.
- Mid-operation reset: assert rst_i during MEM of a store -> dmem_we_o drops to 0 asynchronously; PC=BOOT_ADDR.
